spiresp: RTL and testbench
==========================

// Module: spiresp
// PURPOSE
//  FPGA->ESP32 return path of the SPI command link. Core logic pushes event bytes
//  into a FIFO; on a read command this block returns a byte stream on spi_txdata.
//  spi_txdata is a registered output, advanced one byte per spi_tx_next pulse.
//  Sits beside the SPI slave, opposite the write-register decoder.
// PARAMETERS
//  DEPTH  16  event FIFO depth, power of 2, 2..128
//  AW     4   log2(DEPTH), pointer width; count is AW+1 bits
// PORTS
//  clk            in   1   system clock
//  reset          in   1   async active-high reset
//  spi_cmd_valid  in   1   1-clk pulse: command byte received, spi_cmd valid
//  spi_cmd        in   8   command byte
//  spi_tx_next    in   1   1-clk pulse: current spi_txdata consumed, present next
//  spi_msg_end    in   1   1-clk pulse: chip-select deasserted, message over
//  spi_txdata     out  8   byte presented to the SPI slave shifter
//  evt_wr         in   1   push evt_data into event FIFO
//  evt_data       in   8   event byte
//  status_in      in   32  core status word, sampled on read-status command
//  evt_pending    out  1   FIFO not empty (registered)
// BEHAVIOUR
//  Reset values: state IDLE, spi_txdata=FFh, FIFO empty (count=0), ovf=0, evt_pending=0.
//  Commands: 20h GET_STATUS, 21h GET_EVENTS; any other value -> IDLE, spi_txdata=FFh.
//  spi_cmd_valid at edge N: state/index load; byte0 on spi_txdata from edge N+1.
//  spi_tx_next at edge M: index+1, next byte on spi_txdata from M+1.
//  SPI slave guarantees >=8 clk between spi_tx_next pulses.
//  spi_cmd_valid in a non-IDLE state restarts with the new command.
//  FSM IDLE/STATUS/EVENTS; spi_msg_end -> IDLE, spi_txdata=FFh; spi_msg_end wins over same-cycle spi_tx_next.
//  STATUS stream:
//   byte0={ovf,full,empty,5'b0}; byte1=count zero-extended to 8 bits;
//   bytes2..5=status_in[7:0],[15:8],[23:16],[31:24], status_in snapshotted at cmd edge;
//   byte6+ = FFh.
//  spi_msg_end while in STATUS clears ovf; a same-cycle overflowing push keeps ovf=1.
//  EVENTS stream:
//   byte0 = N = count snapshot at cmd edge.
//   On each spi_tx_next with index<N: spi_txdata<=FIFO head, pop 1 (same edge).
//   Index>=N: spi_txdata=FFh, no pop.
//   N=0: stream is 00h, then FFh.
//   Events pushed after the snapshot are not streamed and stay for the next read.
//   spi_msg_end mid-stream: unpopped events remain queued; popped bytes count as delivered.
//  FIFO:
//   Push accepted when count<DEPTH, or when full with a pop in the same cycle.
//   Otherwise the byte is dropped and ovf set (sticky).
//   Simultaneous push+pop: count unchanged.
//   Pointers wrap modulo DEPTH.
//  evt_pending = (count!=0), registered, 1 clk after the count change.
//  Reset asserted mid-message: everything returns to reset values immediately; queued events are lost.
// TESTING
//  1 Reset; GET_STATUS, 7 tx_next -> 20h,00h,status_in bytes LSB first, FFh,FFh.
//  2 Push 01h,02h,03h; GET_EVENTS, 4 tx_next -> 03h,01h,02h,03h,FFh; evt_pending 0.
//  3 Push 18 bytes (DEPTH=16) -> count 16, ovf=1; GET_STATUS byte0=C0h, byte1=10h;
//    after msg_end, next GET_STATUS byte0=40h.
//  4 Push 5; GET_EVENTS, read 2, msg_end; GET_EVENTS -> 03h then remaining 3 bytes in order.
//  5 Full FIFO, evt_wr on the same clk as a pop -> push accepted, count stays 16, ovf=0.
//  6 Reset pulse mid-EVENTS -> spi_txdata=FFh, count 0, new GET_EVENTS returns 00h.

Source files
------------

// File: rtl/spiresp.sv
// SPI return path: streams a status snapshot or queued event bytes back to the
// SPI slave shifter, one byte per spi_tx_next pulse.
module spiresp #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        spi_cmd_valid,
    input  logic [7:0]  spi_cmd,
    input  logic        spi_tx_next,
    input  logic        spi_msg_end,
    output logic [7:0]  spi_txdata,
    input  logic        evt_wr,
    input  logic [7:0]  evt_data,
    input  logic [31:0] status_in,
    output logic        evt_pending
);
    typedef enum logic [1:0] {IDLE, STATUS, EVENTS} state_t;

    localparam logic [7:0]  CMD_STATUS = 8'h20;
    localparam logic [7:0]  CMD_EVENTS = 8'h21;
    localparam logic [AW:0] FULL_CNT   = DEPTH[AW:0];

    state_t        state, state_nxt;
    logic [7:0]    idx, idx_nxt;
    logic [7:0]    tx_nxt;
    logic          snap_ld;
    logic [31:0]   stat_snap;
    logic [AW:0]   cnt_snap;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [AW:0]   count;
    logic          ovf;
    logic          full, empty, pop, push_ok, ovf_hit;

    function automatic logic [7:0] status_byte(input logic [7:0] sel,
                                               input logic [31:0] snap,
                                               input logic [AW:0] cnt);
        case (sel)
            8'd1:    status_byte = 8'(cnt);
            8'd2:    status_byte = snap[7:0];
            8'd3:    status_byte = snap[15:8];
            8'd4:    status_byte = snap[23:16];
            8'd5:    status_byte = snap[31:24];
            default: status_byte = 8'hFF;
        endcase
    endfunction

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    // A full FIFO still takes a push when the same cycle frees a slot.
    assign push_ok = evt_wr && (!full || pop);
    assign ovf_hit = evt_wr && !push_ok;

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        tx_nxt    = spi_txdata;
        pop       = 1'b0;
        snap_ld   = 1'b0;
        if (spi_msg_end) begin
            state_nxt = IDLE;
            idx_nxt   = '0;
            tx_nxt    = 8'hFF;
        end else if (spi_cmd_valid) begin
            idx_nxt = '0;
            snap_ld = 1'b1;
            case (spi_cmd)
                CMD_STATUS: begin
                    state_nxt = STATUS;
                    tx_nxt    = {ovf, full, empty, 5'b0};
                end
                CMD_EVENTS: begin
                    state_nxt = EVENTS;
                    tx_nxt    = 8'(count);
                end
                default: begin
                    state_nxt = IDLE;
                    tx_nxt    = 8'hFF;
                end
            endcase
        end else if (spi_tx_next) begin
            idx_nxt = (idx == 8'hFF) ? idx : idx + 8'd1;
            case (state)
                STATUS:  tx_nxt = status_byte(idx_nxt, stat_snap, cnt_snap);
                EVENTS: begin
                    // Only the events counted at the command edge are streamed.
                    if (idx < 8'(cnt_snap) && !empty) begin
                        tx_nxt = mem[rd_ptr];
                        pop    = 1'b1;
                    end else begin
                        tx_nxt = 8'hFF;
                    end
                end
                default: tx_nxt = 8'hFF;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            idx        <= '0;
            spi_txdata <= 8'hFF;
            cnt_snap   <= '0;
        end else begin
            state      <= state_nxt;
            idx        <= idx_nxt;
            spi_txdata <= tx_nxt;
            if (snap_ld) cnt_snap <= count;
        end
    end

    always_ff @(posedge clk) begin
        if (snap_ld) stat_snap <= status_in;
        if (push_ok) mem[wr_ptr] <= evt_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            ovf         <= 1'b0;
            evt_pending <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop)     rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
            // A dropped push in the same cycle as the status read's end keeps ovf set.
            if (ovf_hit)
                ovf <= 1'b1;
            else if (spi_msg_end && state == STATUS)
                ovf <= 1'b0;
            evt_pending <= (count != '0);
        end
    end
endmodule

// File: tb/tb_spiresp.sv
// Scoreboard bench for spiresp: expected bytes are queued as stimulus is driven
// and checked against spi_txdata one cycle after each command/advance edge.
module tb_spiresp;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        spi_cmd_valid = 1'b0;
    logic [7:0]  spi_cmd = 8'h00;
    logic        spi_tx_next = 1'b0;
    logic        spi_msg_end = 1'b0;
    logic [7:0]  spi_txdata;
    logic        evt_wr = 1'b0;
    logic [7:0]  evt_data = 8'h00;
    logic [31:0] status_in = 32'h0;
    logic        evt_pending;

    int checks = 0;
    int errors = 0;
    logic [7:0] sb[$];

    spiresp #(.DEPTH(16), .AW(4)) dut (
        .clk(clk), .reset(reset),
        .spi_cmd_valid(spi_cmd_valid), .spi_cmd(spi_cmd),
        .spi_tx_next(spi_tx_next), .spi_msg_end(spi_msg_end),
        .spi_txdata(spi_txdata),
        .evt_wr(evt_wr), .evt_data(evt_data),
        .status_in(status_in), .evt_pending(evt_pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%02h exp=%02h", tag, got, exp);
        end
    endtask

    task automatic expect_tx(input string tag);
        logic [7:0] e;
        e = (sb.size() != 0) ? sb.pop_front() : 8'hxx;
        chk(tag, spi_txdata, e);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic cmd(input logic [7:0] c, input logic [7:0] exp, input string tag);
        sb.push_back(exp);
        spi_cmd = c;
        spi_cmd_valid = 1'b1;
        @(posedge clk); #1;
        spi_cmd_valid = 1'b0;
        expect_tx(tag);
        idle(2);
    endtask

    task automatic tx_next(input logic [7:0] exp, input string tag,
                           input logic with_push = 1'b0, input logic [7:0] pd = 8'h00);
        sb.push_back(exp);
        spi_tx_next = 1'b1;
        evt_wr = with_push;
        evt_data = pd;
        @(posedge clk); #1;
        spi_tx_next = 1'b0;
        evt_wr = 1'b0;
        expect_tx(tag);
        idle(8);
    endtask

    task automatic msg_end(input logic also_next, input string tag);
        sb.push_back(8'hFF);
        spi_msg_end = 1'b1;
        spi_tx_next = also_next;
        @(posedge clk); #1;
        spi_msg_end = 1'b0;
        spi_tx_next = 1'b0;
        expect_tx(tag);
        idle(2);
    endtask

    task automatic push(input logic [7:0] d);
        evt_data = d;
        evt_wr = 1'b1;
        @(posedge clk); #1;
        evt_wr = 1'b0;
    endtask

    task automatic do_reset();
        sb.push_back(8'hFF);
        reset = 1'b1;
        #2;
        expect_tx("rst_txdata");
        chk("rst_pending", {7'b0, evt_pending}, 8'h00);
        @(posedge clk); #1;
        reset = 1'b0;
        idle(2);
    endtask

    initial begin
        logic [7:0] st_bytes [6];
        #1;
        idle(2);
        do_reset();

        // 1: status stream, snapshot held even though status_in changes afterwards
        status_in = 32'hA1B2C3D4;
        cmd(8'h20, 8'h20, "st_b0");
        status_in = 32'h0;
        st_bytes = '{8'h00, 8'hD4, 8'hC3, 8'hB2, 8'hA1, 8'hFF};
        foreach (st_bytes[i]) tx_next(st_bytes[i], $sformatf("st_b%0d", i + 1));
        tx_next(8'hFF, "st_b7");
        msg_end(1'b0, "st_end");
        cmd(8'h55, 8'hFF, "bad_cmd");

        // 2: three events drained in order
        push(8'h01); push(8'h02); push(8'h03);
        idle(1);
        chk("pend_set", {7'b0, evt_pending}, 8'h01);
        cmd(8'h21, 8'h03, "ev_n");
        tx_next(8'h01, "ev_b1");
        tx_next(8'h02, "ev_b2");
        tx_next(8'h03, "ev_b3");
        tx_next(8'hFF, "ev_b4");
        chk("pend_clr", {7'b0, evt_pending}, 8'h00);
        msg_end(1'b0, "ev_end");

        // 3: overflow, ovf cleared at end of status read
        do_reset();
        for (int i = 0; i < 18; i++) push(8'h40 + 8'(i));
        cmd(8'h20, 8'hC0, "ovf_b0");
        tx_next(8'h10, "ovf_cnt");
        msg_end(1'b0, "ovf_end");
        cmd(8'h20, 8'h40, "ovf_clr_b0");
        msg_end(1'b1, "end_beats_next");
        cmd(8'h21, 8'h10, "restart_ev");
        cmd(8'h20, 8'h40, "restart_st");
        msg_end(1'b0, "restart_end");

        // 4: partial read leaves the rest queued; late push waits for next read
        do_reset();
        for (int i = 0; i < 5; i++) push(8'h50 + 8'(i));
        cmd(8'h21, 8'h05, "part_n");
        tx_next(8'h50, "part_b1");
        tx_next(8'h51, "part_b2");
        msg_end(1'b0, "part_end");
        cmd(8'h21, 8'h03, "rest_n");
        push(8'h99);
        tx_next(8'h52, "rest_b1");
        tx_next(8'h53, "rest_b2");
        tx_next(8'h54, "rest_b3");
        tx_next(8'hFF, "rest_past_n");
        msg_end(1'b0, "rest_end");
        cmd(8'h21, 8'h01, "late_n");
        tx_next(8'h99, "late_b1");
        tx_next(8'hFF, "late_ff");
        msg_end(1'b0, "late_end");

        // 5: push into full FIFO on the same edge as a pop
        do_reset();
        for (int i = 0; i < 16; i++) push(8'(i));
        cmd(8'h21, 8'h10, "fp_n");
        tx_next(8'h00, "fp_b1", 1'b1, 8'hAA);
        msg_end(1'b0, "fp_end");
        cmd(8'h20, 8'h40, "fp_st_b0");
        tx_next(8'h10, "fp_st_cnt");
        msg_end(1'b0, "fp_st_end");
        cmd(8'h21, 8'h10, "fp_n2");
        for (int i = 1; i < 16; i++) tx_next(8'(i), $sformatf("fp2_b%0d", i));
        tx_next(8'hAA, "fp2_tail");
        msg_end(1'b0, "fp2_end");

        // 6: reset in the middle of an event stream
        push(8'h11); push(8'h22); push(8'h33);
        cmd(8'h21, 8'h03, "mr_n");
        tx_next(8'h11, "mr_b1");
        do_reset();
        cmd(8'h21, 8'h00, "mr_empty_n");
        tx_next(8'hFF, "mr_empty_ff");
        msg_end(1'b0, "mr_end");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
